// File: rtl/output_record_writer_pkg.sv
// Shared record geometry, serializer state type and record type for the
// output record writer and its FIFO.
package out_writer_pkg;

  localparam int ADDR_W        = 16;
  localparam int DATA_W        = 24;
  localparam int RECORD_W      = ADDR_W + DATA_W;
  localparam int BYTE_W        = 8;
  localparam int BYTES_PER_REC = 5;

  typedef enum logic {IDLE, SEND} wr_state_t;

  typedef logic [RECORD_W-1:0] record_t;

endpackage

// File: rtl/output_record_writer_sync_fifo.sv
// Register-based synchronous FIFO with occupancy count and synchronous flush.
// Read data is the entry at the read pointer (first-word fall-through).
module sync_fifo #(
  parameter  int WIDTH = 40,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH; full/empty come from the count alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/output_record_writer.sv
// Captures distinct 40-bit output records into a FIFO and streams them
// MSB-first as five bytes over a valid/ready byte interface.
module output_record_writer
  import out_writer_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int DEDUP = 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [RECORD_W-1:0] data_in,
  input  logic                enable_in,
  output logic [BYTE_W-1:0]   byte_out,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic [CW-1:0]       fifo_count,
  output logic                overflow,
  output logic                busy
);

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_REC - 1);

  wr_state_t state, state_next;
  record_t   shift, shift_next;
  logic [2:0] idx, idx_next;
  record_t   last_rec;
  logic      last_valid;
  logic      capture;
  logic      push;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;
  record_t   fifo_rdata;

  assign capture = enable_in && ((DEDUP == 0) || !last_valid || (data_in != last_rec));
  assign push    = capture && !fifo_full && !clear;

  sync_fifo #(
    .WIDTH(RECORD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A held record is remembered even when dropped, so it costs one drop only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_rec   <= '0;
      last_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      last_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (capture) begin
      last_rec   <= data_in;
      last_valid <= 1'b1;
      if (fifo_full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      shift <= shift_next;
      idx   <= idx_next;
    end
  end

  // The last byte's handshake reloads directly from the FIFO to avoid a bubble.
  always_comb begin
    state_next = state;
    shift_next = shift;
    idx_next   = idx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_rdata;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (byte_ready) begin
          if (idx != LAST_IDX) begin
            shift_next = shift << BYTE_W;
            idx_next   = idx + 3'd1;
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_rdata;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (clear) begin
      pop        = 1'b0;
      state_next = IDLE;
      idx_next   = '0;
    end
  end

  assign byte_valid = (state == SEND);
  assign byte_out   = byte_valid ? shift[RECORD_W-1 -: BYTE_W] : '0;
  assign busy       = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_output_record_writer.sv
// Directed bench for output_record_writer: vector table for single records,
// plus sequences for dedup, overflow, stalls, clear and async reset.
module tb_output_record_writer;
  import out_writer_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [39:0] rec;
    logic [7:0]  b0, b1, b2, b3, b4;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic [39:0]   data_in = '0;
  logic          enable_in = 1'b0;
  logic          byte_ready = 1'b0;

  logic [7:0]    a_byte, b_byte;
  logic          a_valid, b_valid;
  logic [CW-1:0] a_count, b_count;
  logic          a_overflow, b_overflow;
  logic          a_busy, b_busy;

  int            numCompared = 0;
  int            numMismatched = 0;
  logic [7:0]    aBytes[$];
  logic [7:0]    bBytes[$];
  bit            stallCheck = 1'b0;
  bit            prevStall = 1'b0;
  logic [7:0]    prevByte = '0;
  vec_t          vecs[4];
  vec_t          freshVec;

  output_record_writer #(.DEPTH(DEPTH), .DEDUP(1)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .data_in(data_in),
    .enable_in(enable_in), .byte_out(a_byte), .byte_valid(a_valid),
    .byte_ready(byte_ready), .fifo_count(a_count), .overflow(a_overflow),
    .busy(a_busy)
  );

  output_record_writer #(.DEPTH(DEPTH), .DEDUP(0)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .data_in(data_in),
    .enable_in(enable_in), .byte_out(b_byte), .byte_valid(b_valid),
    .byte_ready(byte_ready), .fifo_count(b_count), .overflow(b_overflow),
    .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    numCompared++;
    if (act !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Inputs are stable at the falling edge, so valid&&ready here is the handshake
  always @(negedge clk) begin
    if (reset) begin
      if (a_valid && byte_ready) aBytes.push_back(a_byte);
      if (b_valid && byte_ready) bBytes.push_back(b_byte);
    end
    if (stallCheck && prevStall) begin
      checkOutput("stall_valid", 40'(a_valid), 40'h1);
      checkOutput("stall_hold", 40'(a_byte), 40'(prevByte));
    end
    prevStall = a_valid && !byte_ready;
    prevByte  = a_byte;
  end

  task automatic applyStimulus(input vec_t v);
    logic [7:0] e [5];
    e[0] = v.b0; e[1] = v.b1; e[2] = v.b2; e[3] = v.b3; e[4] = v.b4;
    data_in   = v.rec;
    enable_in = 1'b1;
    tick();
    enable_in = 1'b0;
    checkOutput("capture_count", 40'(a_count), 40'h1);
    checkOutput("early_valid", 40'(a_valid), 40'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("byte_valid", 40'(a_valid), 40'h1);
      checkOutput("byte_value", 40'(a_byte), 40'(e[k]));
      tick();
    end
    checkOutput("after_valid", 40'(a_valid), 40'h0);
    checkOutput("after_busy", 40'(a_busy), 40'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{40'h0012ABCDEF, 8'h00, 8'h12, 8'hAB, 8'hCD, 8'hEF};
    vecs[1] = '{40'hFFFF000000, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{40'h80017F8001, 8'h80, 8'h01, 8'h7F, 8'h80, 8'h01};
    vecs[3] = '{40'hA5A55A5A5A, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h5A};
    freshVec = '{40'h0102030405, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    byte_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst_byte", 40'(a_byte), 40'h0);
    checkOutput("rst_valid", 40'(a_valid), 40'h0);
    checkOutput("rst_count", 40'(a_count), 40'h0);
    checkOutput("rst_overflow", 40'(a_overflow), 40'h0);
    checkOutput("rst_busy", 40'(a_busy), 40'h0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Held record: one copy with dedup, ten copies without
    pulseClear();
    aBytes.delete();
    bBytes.delete();
    data_in   = 40'h0A0B0C0D0E;
    enable_in = 1'b1;
    repeat (10) tick();
    enable_in = 1'b0;
    repeat (70) tick();
    checkOutput("dedup_count", 40'(aBytes.size()), 40'd5);
    checkOutput("nodedup_count", 40'(bBytes.size()), 40'd50);
    if (aBytes.size() >= 5) begin
      checkOutput("dedup_first", 40'(aBytes[0]), 40'h0A);
      checkOutput("dedup_last", 40'(aBytes[4]), 40'h0E);
    end
    if (bBytes.size() >= 50) begin
      checkOutput("nodedup_rec10", 40'(bBytes[45]), 40'h0A);
      checkOutput("nodedup_end", 40'(bBytes[49]), 40'h0E);
    end
    checkOutput("nodedup_overflow", 40'(b_overflow), 40'h0);

    // Overflow: one record in the shifter plus DEPTH queued, then one dropped
    pulseClear();
    aBytes.delete();
    byte_ready = 1'b0;
    enable_in  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data_in = {16'h5000 + 16'(i), 24'hABC000 + 24'(i)};
      tick();
    end
    checkOutput("full_count", 40'(a_count), 40'd16);
    checkOutput("full_no_overflow", 40'(a_overflow), 40'h0);
    data_in = 40'h5FFF_FFFFFF;
    tick();
    enable_in = 1'b0;
    checkOutput("drop_count", 40'(a_count), 40'd16);
    checkOutput("drop_overflow", 40'(a_overflow), 40'h1);
    checkOutput("stalled_byte", 40'(a_byte), 40'h50);
    byte_ready = 1'b1;
    for (int t = 0; t < 150 && aBytes.size() < 85; t++) tick();
    repeat (4) tick();
    checkOutput("drain_size", 40'(aBytes.size()), 40'd85);
    if (aBytes.size() >= 85) begin
      for (int r = 0; r < 17; r++) begin
        logic [39:0] expRec;
        expRec = {16'h5000 + 16'(r), 24'hABC000 + 24'(r)};
        for (int k = 0; k < 5; k++)
          checkOutput("drain_byte", 40'(aBytes[r*5+k]), 40'(expRec[39-8*k -: 8]));
      end
    end
    checkOutput("sticky_overflow", 40'(a_overflow), 40'h1);

    // Clear after the second byte, with a capture in the same cycle
    data_in   = 40'h1122334455;
    enable_in = 1'b1;
    tick();
    data_in   = 40'hAABBCCDDEE;
    tick();
    enable_in = 1'b0;
    tick();
    tick();
    checkOutput("pre_clear_byte", 40'(a_byte), 40'h33);
    checkOutput("pre_clear_count", 40'(a_count), 40'h1);
    checkOutput("pre_clear_overflow", 40'(a_overflow), 40'h1);
    clear     = 1'b1;
    enable_in = 1'b1;
    data_in   = 40'h6677889900;
    tick();
    clear     = 1'b0;
    enable_in = 1'b0;
    checkOutput("clear_valid", 40'(a_valid), 40'h0);
    checkOutput("clear_byte", 40'(a_byte), 40'h0);
    checkOutput("clear_count", 40'(a_count), 40'h0);
    checkOutput("clear_overflow", 40'(a_overflow), 40'h0);
    checkOutput("clear_busy", 40'(a_busy), 40'h0);
    repeat (3) tick();
    checkOutput("clear_nocapture", 40'(a_count), 40'h0);
    checkOutput("clear_still_idle", 40'(a_valid), 40'h0);
    data_in   = 40'hAABBCCDDEE;
    enable_in = 1'b1;
    tick();
    enable_in = 1'b0;
    checkOutput("clear_forgets_last", 40'(a_count), 40'h1);
    repeat (8) tick();

    // Alternating ready across two back-to-back records
    pulseClear();
    aBytes.delete();
    byte_ready = 1'b0;
    stallCheck = 1'b1;
    data_in    = 40'h0123456789;
    enable_in  = 1'b1;
    tick();
    data_in    = 40'hFEDCBA9876;
    tick();
    enable_in  = 1'b0;
    for (int t = 0; t < 40; t++) begin
      byte_ready = ~byte_ready;
      tick();
    end
    byte_ready = 1'b1;
    repeat (6) tick();
    stallCheck = 1'b0;
    checkOutput("toggle_size", 40'(aBytes.size()), 40'd10);
    if (aBytes.size() >= 10) begin
      checkOutput("toggle_b0", 40'(aBytes[0]), 40'h01);
      checkOutput("toggle_b4", 40'(aBytes[4]), 40'h89);
      checkOutput("toggle_b5", 40'(aBytes[5]), 40'hFE);
      checkOutput("toggle_b7", 40'(aBytes[7]), 40'hBA);
      checkOutput("toggle_b9", 40'(aBytes[9]), 40'h76);
    end

    // Asynchronous reset in the middle of a record
    pulseClear();
    data_in   = 40'h3344556677;
    enable_in = 1'b1;
    tick();
    enable_in = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("pre_reset_byte", 40'(a_byte), 40'h55);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("areset_valid", 40'(a_valid), 40'h0);
    checkOutput("areset_byte", 40'(a_byte), 40'h0);
    checkOutput("areset_count", 40'(a_count), 40'h0);
    checkOutput("areset_busy", 40'(a_busy), 40'h0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("post_reset_idle", 40'(a_valid), 40'h0);
    applyStimulus(freshVec);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
